x25519_host_ctrl: RTL and testbench
===================================

// Module: x25519_host_ctrl
// PURPOSE
//  Hardware initiator for the X25519 scalar-multiplication core. It takes the scalar and the
//  u-coordinate as a word stream, sequences the core's reset-as-start protocol and waits for
//  valid, then returns the 256-bit result as a word stream. It sits between the RoT
//  command/stream fabric and the X25519 instance.
// PARAMETERS
//  BIT_LENGTH      256      operand/result width; must be a multiple of WORD_W
//  WORD_W          32       stream word width
//  TIMEOUT_CYCLES  2000000  max cycles in RUN before abort; 0 = no timeout
// PORTS
//  clk             in   1           system clock
//  rst             in   1           synchronous, active-high reset
//  in_valid        in   1           input word valid
//  in_ready        out  1           controller accepts input word
//  in_data         in   WORD_W      input word; 8 scalar words, then 8 point words, MSW first
//  out_valid       out  1           result word valid
//  out_ready       in   1           sink accepts result word
//  out_data        out  WORD_W      result word, MSW first
//  out_last        out  1           marks final result word (index NW-1)
//  out_err         out  1           job timed out; held for all result words of that job
//  busy            out  1           high in any state other than LOAD
//  core_rst        out  1           to X25519 rst; high holds core idle, low runs it
//  core_scalar     out  BIT_LENGTH  to X25519 scalar
//  core_point      out  BIT_LENGTH  to X25519 point_in
//  core_point_out  in   BIT_LENGTH  from X25519 point_out
//  core_valid      in   1           from X25519 valid
// BEHAVIOUR
//  NW = BIT_LENGTH/WORD_W (8 by default). An accepted word is one with in_valid & in_ready;
//  a transfered word is one with out_valid & out_ready.
//  Reset: state=LOAD, word counter=0, in_ready=1, out_valid=0, out_last=0, out_err=0,
//   busy=0, core_rst=1, core_scalar=0, core_point=0, result reg=0, timeout counter=0.
//  LOAD: in_ready=1; core_rst=1.
//   Accepted word k (0..NW-1) shifts into core_scalar from the LSW end, so word 0 ends in
//   [BIT_LENGTH-1 -: WORD_W]. Words NW..2NW-1 fill core_point the same way.
//   On accepting word 2NW-1: next cycle state=RUN, in_ready=0, core_rst=0.
//   core_scalar and core_point stay stable until the next LOAD.
//  RUN: core_rst=0; timeout counter increments each cycle; core_valid is sampled each cycle.
//   core_valid=1: capture core_point_out into result reg, out_err<=0, core_rst<=1, go OUT.
//   Counter == TIMEOUT_CYCLES-1 without core_valid (TIMEOUT_CYCLES!=0): result reg<=0,
//   out_err<=1, core_rst<=1, go OUT. If core_valid is high that same cycle, valid wins.
//  OUT: out_valid=1; out_data = result[BIT_LENGTH-1 -: WORD_W].
//   On each transfer, result shifts left by WORD_W and the word index increments.
//   out_last=1 while the index equals NW-1.
//   out_data/out_last/out_err hold stable while out_valid & !out_ready.
//   After the transfer of word NW-1: next cycle state=LOAD, out_valid=0, out_err=0,
//   in_ready=1, counters=0.
//  core_rst is registered. It is high for at least 1 cycle between jobs, so each job
//   restarts the core from reset. The first RUN cycle is the first cycle with core_rst=0.
//  Latency: last input accept -> core_rst low = 1 cycle.
//   core_valid seen -> out_valid high = 1 cycle.
//  Input words offered outside LOAD are not accepted (in_ready=0); nothing is dropped.
//  rst asserted in any state returns all registers to their reset values on the next edge.
//   Any partial load or running job is discarded, and core_rst returns high.
// TESTING
//  T1 RFC7748 vector: scalar 77076d0a..b92c2a, point 0900..00, with the real X25519 core
//   -> 8 out words equal the core's point_out MSW first; out_last only on word 7;
//   out_err=0.
//  T2 Stub core (valid 50 cycles after core_rst falls, point_out=0x0123..EF pattern)
//   -> out_valid rises exactly 1 cycle after core_valid; core_rst high after the capture.
//  T3 Backpressure: out_ready toggles 1/0 every cycle; in_valid with gaps during LOAD
//   -> words neither lost nor duplicated; out_data stable while stalled.
//  T4 Timeout: TIMEOUT_CYCLES=100, stub never raises valid
//   -> 8 words of 0 with out_err=1; core_rst high; the next job completes with out_err=0.
//  T5 rst pulsed after 5 input words, then in RUN
//   -> in_ready=1, busy=0, core_rst=1 next cycle; a fresh 16-word job gives the
//   correct result.
//  T6 in_valid held high during RUN/OUT -> in_ready=0; back-to-back jobs give results
//   in order.

Source files
------------

// File: rtl/x25519_host_ctrl.sv
// ============================================================================
// Module  : x25519_host_ctrl
// Purpose : Host-side initiator for an X25519 scalar-multiplication core.
//           Gathers scalar and u-coordinate from a word stream, runs the core
//           through its reset-as-start protocol, waits for valid (or a
//           timeout), then streams the 256-bit result back out MSW first.
// Ports   : clk, rst                    - clock, synchronous active-high reset
//           in_valid/in_ready/in_data   - input stream (NW scalar words, then
//                                         NW point words, MSW first)
//           out_valid/out_ready/out_data/out_last/out_err
//                                       - result stream; out_err flags timeout
//           busy                        - controller not in LOAD
//           core_rst/core_scalar/core_point/core_point_out/core_valid
//                                       - connection to the X25519 core
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module x25519_host_ctrl #(
  parameter int BIT_LENGTH     = 256,
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy,
  output logic                  core_rst,
  output logic [BIT_LENGTH-1:0] core_scalar,
  output logic [BIT_LENGTH-1:0] core_point,
  input  logic [BIT_LENGTH-1:0] core_point_out,
  input  logic                  core_valid
);

  localparam int NW = BIT_LENGTH / WORD_W;
  localparam int CW = $clog2(2 * NW);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST_IN  = CW'(2 * NW - 1);
  localparam logic [CW-1:0] C_LAST_OUT = CW'(NW - 1);
  localparam logic [CW-1:0] C_NW       = CW'(NW);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [BIT_LENGTH-1:0] scalar_q, scalar_d;
  logic [BIT_LENGTH-1:0] point_q, point_d;
  logic [BIT_LENGTH-1:0] result_q, result_d;
  logic                  err_q, err_d;
  logic                  core_rst_q, core_rst_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      tmo_q      <= '0;
      scalar_q   <= '0;
      point_q    <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      scalar_q   <= scalar_d;
      point_q    <= point_d;
      result_q   <= result_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    scalar_d   = scalar_q;
    point_d    = point_q;
    result_d   = result_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + CW'(1);
          // Shifting in at the LSW end leaves the first word at the MSW end.
          if (cnt_q < C_NW) begin
            scalar_d = {scalar_q[BIT_LENGTH-WORD_W-1:0], in_data};
          end else begin
            point_d = {point_q[BIT_LENGTH-WORD_W-1:0], in_data};
          end
          if (cnt_q == C_LAST_IN) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            tmo_d      = '0;
            core_rst_d = 1'b0;
          end
        end
      end

      S_RUN: begin
        tmo_d = tmo_q + TW'(1);
        // A result arriving on the timeout cycle itself still counts as good.
        if (core_valid) begin
          result_d   = core_point_out;
          err_d      = 1'b0;
          core_rst_d = 1'b1;
          state_d    = S_OUT;
          cnt_d      = '0;
          tmo_d      = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == C_TMO_LAST)) begin
          result_d   = '0;
          err_d      = 1'b1;
          core_rst_d = 1'b1;
          state_d    = S_OUT;
          cnt_d      = '0;
          tmo_d      = '0;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          result_d = result_q << WORD_W;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == C_LAST_OUT) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_OUT);
  assign busy        = (state_q != S_LOAD);
  assign out_data    = result_q[BIT_LENGTH-1 -: WORD_W];
  assign out_last    = (state_q == S_OUT) && (cnt_q == C_LAST_OUT);
  assign out_err     = err_q;
  assign core_rst    = core_rst_q;
  assign core_scalar = scalar_q;
  assign core_point  = point_q;

endmodule

`default_nettype wire

// File: tb/tb_x25519_host_ctrl.sv
`default_nettype none

module tb_x25519_host_ctrl;

  localparam int BL  = 256;
  localparam int WW  = 32;
  localparam int NW  = 8;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          out_err;
  logic          busy;
  logic          core_rst;
  logic [BL-1:0] core_scalar;
  logic [BL-1:0] core_point;
  logic [BL-1:0] core_point_out;
  logic          core_valid;

  x25519_host_ctrl #(
    .BIT_LENGTH    (BL),
    .WORD_W        (WW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_err       (out_err),
    .busy          (busy),
    .core_rst      (core_rst),
    .core_scalar   (core_scalar),
    .core_point    (core_point),
    .core_point_out(core_point_out),
    .core_valid    (core_valid)
  );

  always #5 clk = ~clk;

  // Stub core: valid rises stub_delay cycles after core_rst falls and stays
  // high until core_rst returns; result depends on both loaded operands.
  int stub_cnt;
  int stub_delay;
  always @(posedge clk) begin
    if (core_rst) stub_cnt <= 0;
    else          stub_cnt <= stub_cnt + 1;
  end
  assign core_valid     = !core_rst && (stub_cnt >= stub_delay);
  assign core_point_out = core_scalar ^ core_point;

  typedef struct {
    logic [BL-1:0] scalar;
    logic [BL-1:0] point;
    int            delay;
    bit            exp_err;
    bit            bp;
    bit            gaps;
    bit            hold;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input bit gaps);
    int b;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    b = 0;
    while (!in_ready && b < 1000) begin
      tick();
      b++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_words(input logic [BL-1:0] s, input logic [BL-1:0] p,
                            input int nwords, input bit gaps);
    for (int i = 0; i < nwords; i++) begin
      if (i < NW) send_word(s[BL-1-WW*i -: WW], gaps);
      else        send_word(p[BL-1-WW*(i-NW) -: WW], gaps);
    end
  endtask

  task automatic pulse_rst();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_scalar", core_scalar, 0);
  endtask

  task automatic run_job(input vec_t v);
    logic [BL-1:0] exp_res;
    int            exp_lat;
    int            n;
    int            w;
    int            b;
    bit            tog;
    stub_delay = v.delay;
    exp_res    = v.exp_err ? '0 : (v.scalar ^ v.point);
    exp_lat    = v.exp_err ? TMO : v.delay + 1;
    load_words(v.scalar, v.point, 2 * NW, v.gaps);
    // One cycle after the final accept the core must be released.
    check("core_rst_low", core_rst, 0);
    check("run_in_ready", in_ready, 0);
    check("run_busy", busy, 1);
    check("core_scalar", core_scalar, v.scalar);
    check("core_point", core_point, v.point);
    if (v.hold) begin
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
    end
    n = 0;
    while (!out_valid && n < 2000) begin
      tick();
      n++;
      if (v.hold && !out_valid) check("hold_run_in_ready", in_ready, 0);
    end
    check("latency", n, exp_lat);
    check("core_rst_after", core_rst, 1);
    w   = 0;
    b   = 0;
    tog = 1'b0;
    while (w < NW && b < 200) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_res[BL-1-WW*w -: WW]);
      check("out_last", out_last, (w == NW - 1));
      check("out_err", out_err, v.exp_err);
      if (v.hold) check("hold_out_in_ready", in_ready, 0);
      out_ready = v.bp ? tog : 1'b1;
      tog       = ~tog;
      if (out_ready && w == NW - 1) in_valid = 1'b0;
      tick();
      b++;
      if (out_ready) w++;
    end
    if (w < NW) check("out_words", w, NW);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_busy", busy, 0);
    check("end_out_err", out_err, 0);
  endtask

  initial begin
    vecs[0] = '{256'h77076d0a7318a57d3c16c17251b26645df4c2f87ebc0992ab177fba51db92c2a,
                {8'h09, 248'h0}, 50, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{{4{64'h0123456789ABCDEF}}, {4{64'hFEDCBA9876543210}}, 50,
                1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{{8{32'hA5A5_0001}}, {8{32'h5A5A_0002}}, 1000000,
                1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{{8{32'hFFFF_FFFF}}, {8{32'h1111_2222}}, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{{8{32'h8000_0001}}, {8{32'h0F0F_F0F0}}, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{{8{32'h1357_9BDF}}, {8{32'h2468_ACE0}}, TMO - 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{{8{32'hCAFE_F00D}}, {8{32'h0BAD_BEEF}}, TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    stub_delay = 50;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_err", out_err, 0);
    check("reset_busy", busy, 0);
    check("reset_core_rst", core_rst, 1);
    check("reset_scalar", core_scalar, 0);
    check("reset_point", core_point, 0);
    check("reset_out_data", out_data, 0);

    // Abort a partial load, then abort a running job.
    load_words(vecs[1].scalar, vecs[1].point, 5, 1'b0);
    check("partial_busy", busy, 0);
    pulse_rst();
    stub_delay = 40;
    load_words(vecs[1].scalar, vecs[1].point, 2 * NW, 1'b0);
    repeat (10) tick();
    check("mid_run_busy", busy, 1);
    check("mid_run_core_rst", core_rst, 0);
    pulse_rst();

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
